e_mdu: RTL and testbench
========================

// Module: e_mdu
// PURPOSE
//  Execute-stage multiply/divide unit with HI/LO registers. Consumes the
//  operands and decoded MDU op presented by the D->E pipeline register.
//  Runs mult/div over several cycles and raises start/busy so the hazard
//  unit stalls later MDU instructions in D. Suppresses a start that
//  coincides with an interrupt/exception flush.
// PARAMETERS
//  MULT_CYCLES  5   cycles busy stays high after a mult/multu start
//  DIV_CYCLES   10  cycles busy stays high after a div/divu start
// PORTS
//  clk          in   1   clock
//  reset        in   1   synchronous, active-high
//  mdu_op       in   4   decoded op of E instr (`MDU_* codes, 0 = none)
//  rs_val       in   32  forwarded rs operand (E stage)
//  rt_val       in   32  forwarded rt operand (E stage)
//  int_exc_req  in   1   CP0 flush request; E instr is cancelled this cycle
//  start        out  1   comb: mult/multu/div/divu in E and !int_exc_req
//  busy         out  1   registered: operation in flight
//  hi           out  32  HI register
//  lo           out  32  LO register
//  mdu_rdata    out  32  comb: HI for `MDU_MFHI, LO for `MDU_MFLO, else 0
// BEHAVIOUR
//  Reset: busy=0, HI=0, LO=0, counter=0, state IDLE, temp regs=0.
//  FSM: IDLE, RUN.
//   IDLE: start=1 -> latch result into tmp_hi/tmp_lo, load counter with
//    MULT_CYCLES or DIV_CYCLES, go RUN (busy=1 from next cycle).
//   RUN: counter decrements each cycle; at counter==1 commit tmp->HI/LO,
//    busy=0 next cycle, go IDLE. HI/LO unchanged until commit.
//  Arithmetic (computed at start, from operands of that cycle):
//   mult : {HI,LO} = $signed(rs)*$signed(rt), 64-bit
//   multu: {HI,LO} = rs*rt unsigned, 64-bit
//   div  : LO = signed quotient trunc to zero, HI = remainder (sign of rs)
//   divu : LO = rs/rt, HI = rs%rt unsigned
//   0x80000000 div 0xFFFFFFFF -> LO=0x80000000, HI=0.
//   rt==0 for div/divu: op still occupies DIV_CYCLES, HI/LO unchanged.
//  mthi/mtlo: write HI/LO from rs_val at the clock edge, only when state
//   IDLE and !int_exc_req; ignored otherwise (hazard unit prevents it).
//  mfhi/mflo: read current HI/LO combinationally; hazard unit stalls them
//   in D while start|busy, so a read never sees a stale value.
//  int_exc_req with start in same cycle: start forced 0, no op launched.
//  int_exc_req during RUN: in-flight op continues and commits normally.
//  start while RUN: cannot occur (stalled in D); if it does, ignored.
//  reset in RUN: abort, all state to reset values, no commit.
//  Stall contract (hazard unit): stall D when D instr is an MDU instr and
//   (start | busy).
// STRUCTURE
//  Shared header: `MDU_NONE/MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO op
//   codes, FSM state encodings.
//  One natural sub-module: mdu_calc (comb 64-bit mul/div/rem result);
//   e_mdu keeps FSM, counter, HI/LO and control.
// TESTING
//  mult rs=0xFFFFFFFE rt=3 -> start=1, busy 5 cycles, then HI=0xFFFFFFFF
//   LO=0xFFFFFFFA; HI/LO unchanged while busy.
//  multu rs=0xFFFFFFFF rt=2 -> after 5 cycles HI=0x1 LO=0xFFFFFFFE.
//  div rs=-7 rt=2 -> busy 10 cycles, LO=0xFFFFFFFD HI=0xFFFFFFFF;
//   divu rs=7 rt=0 -> busy 10 cycles, HI/LO unchanged.
//  mthi rs=0x1234 idle -> HI=0x1234 next edge; then mfhi -> mdu_rdata=0x1234.
//  div issued with int_exc_req=1 same cycle -> start=0, busy stays 0,
//   HI/LO unchanged; int_exc_req mid-RUN -> op completes and commits.
//  reset asserted 2 cycles into mult -> busy=0, HI=LO=0, no later commit.

Source files
------------

// File: rtl/e_mdu_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit:
// op codes, FSM states, cycle counts and the result record.
package e_mdu_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8
    } mdu_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } mdu_state_e;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;
    localparam int unsigned CNT_W           = 4;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        div_by_zero;
    } mdu_res_t;

    function automatic logic is_arith(input mdu_op_e op);
        return op inside {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU};
    endfunction

    function automatic logic is_div(input mdu_op_e op);
        return op inside {MDU_DIV, MDU_DIVU};
    endfunction

endpackage

// File: rtl/e_mdu_calc.sv
// Combinational 64-bit multiply and 32-bit divide/remainder for the MDU.
// One unsigned divider serves both div and divu via sign-magnitude fixup.
module e_mdu_calc
    import e_mdu_pkg::*;
(
    input  mdu_op_e     op_i,
    input  logic [31:0] rs_i,
    input  logic [31:0] rt_i,
    output mdu_res_t    res_o
);

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic               signed_div;
    logic        [31:0] abs_a;
    logic        [31:0] abs_b;
    logic        [31:0] divisor;
    logic        [31:0] uq;
    logic        [31:0] ur;

    assign prod_s = $signed({{32{rs_i[31]}}, rs_i}) * $signed({{32{rt_i[31]}}, rt_i});
    assign prod_u = {32'b0, rs_i} * {32'b0, rt_i};

    // Working on magnitudes keeps 0x80000000 / -1 well defined (quotient wraps to 0x80000000).
    assign signed_div = (op_i == MDU_DIV);
    assign abs_a      = (signed_div && rs_i[31]) ? -rs_i : rs_i;
    assign abs_b      = (signed_div && rt_i[31]) ? -rt_i : rt_i;
    assign divisor    = (abs_b == 32'd0) ? 32'd1 : abs_b;
    assign uq         = abs_a / divisor;
    assign ur         = abs_a % divisor;

    always_comb begin
        // NOTE: default every output first so no path through the case infers a latch.
        res_o = '0;
        unique case (op_i)
            MDU_MULT:  {res_o.hi, res_o.lo} = prod_s;
            MDU_MULTU: {res_o.hi, res_o.lo} = prod_u;
            MDU_DIV: begin
                res_o.lo          = (rs_i[31] ^ rt_i[31]) ? -uq : uq;
                res_o.hi          = rs_i[31] ? -ur : ur;
                res_o.div_by_zero = (rt_i == 32'd0);
            end
            MDU_DIVU: begin
                res_o.lo          = uq;
                res_o.hi          = ur;
                res_o.div_by_zero = (rt_i == 32'd0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: result is captured at start, held for a
// fixed latency, then committed to HI/LO; start/busy feed the hazard unit.
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        int_exc_req,
    output logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mdu_rdata
);

    mdu_op_e            op;
    mdu_res_t           res;
    mdu_state_e         state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        hi_q;
    logic [31:0]        lo_q;
    logic [31:0]        tmp_hi_q;
    logic [31:0]        tmp_lo_q;
    logic               commit_q;
    logic               busy_q;

    assign op    = mdu_op_e'(mdu_op);
    assign start = is_arith(op) && !int_exc_req;

    e_mdu_calc u_calc (
        .op_i  (op),
        .rs_i  (rs_val),
        .rt_i  (rt_val),
        .res_o (res)
    );

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            tmp_hi_q <= '0;
            tmp_lo_q <= '0;
            commit_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        tmp_hi_q <= res.hi;
                        tmp_lo_q <= res.lo;
                        commit_q <= !res.div_by_zero;
                        cnt_q    <= is_div(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        busy_q   <= 1'b1;
                        state_q  <= S_RUN;
                    end else if (!int_exc_req && op == MDU_MTHI) begin
                        hi_q <= rs_val;
                    end else if (!int_exc_req && op == MDU_MTLO) begin
                        lo_q <= rs_val;
                    end
                end
                S_RUN: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        if (commit_q) begin
                            hi_q <= tmp_hi_q;
                            lo_q <= tmp_lo_q;
                        end
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

    always_comb begin
        mdu_rdata = 32'd0;
        if (op == MDU_MFHI)      mdu_rdata = hi_q;
        else if (op == MDU_MFLO) mdu_rdata = lo_q;
    end

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed vector table, hand-written corner
// sequences and random ops checked against a plain-arithmetic HI/LO model.
module tb_e_mdu;
    import e_mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  mdu_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        int_exc_req;
    logic        start;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mdu_rdata;

    e_mdu dut (
        .clk         (clk),
        .reset       (reset),
        .mdu_op      (mdu_op),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .int_exc_req (int_exc_req),
        .start       (start),
        .busy        (busy),
        .hi          (hi),
        .lo          (lo),
        .mdu_rdata   (mdu_rdata)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    typedef struct {
        mdu_op_e     op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        upd;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: what HI/LO should hold after the op completes.
    task automatic model(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] h, output logic [31:0] l, output logic upd);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        h   = m_hi;
        l   = m_lo;
        upd = 1'b1;
        case (op)
            MDU_MULT:  begin p = sa * sb; {h, l} = p; end
            MDU_MULTU: begin p = {32'b0, a} * {32'b0, b}; {h, l} = p; end
            MDU_DIV: begin
                if (b == 32'd0) upd = 1'b0;
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    l = q[31:0];
                    h = r[31:0];
                end
            end
            MDU_DIVU: begin
                if (b == 32'd0) upd = 1'b0;
                else begin
                    l = a / b;
                    h = a % b;
                end
            end
            default: upd = 1'b0;
        endcase
    endtask

    task automatic run_op(input string name, input mdu_op_e op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input logic upd);
        int n;
        n = (op == MDU_DIV || op == MDU_DIVU) ? 10 : 5;
        mdu_op      = op;
        rs_val      = a;
        rt_val      = b;
        int_exc_req = 1'b0;
        #1;
        check({name, " start"}, 32'(start), 32'd1);
        tick();
        mdu_op = MDU_NONE;
        rs_val = $urandom;
        rt_val = $urandom;
        for (int i = 0; i < n; i++) begin
            check({name, " busy"}, 32'(busy), 32'd1);
            check({name, " hi held"}, hi, m_hi);
            check({name, " lo held"}, lo, m_lo);
            tick();
        end
        check({name, " busy done"}, 32'(busy), 32'd0);
        if (upd) begin
            m_hi = eh;
            m_lo = el;
        end
        check({name, " hi"}, hi, m_hi);
        check({name, " lo"}, lo, m_lo);
        mdu_op = MDU_MFHI;
        #1;
        check({name, " mfhi"}, mdu_rdata, m_hi);
        mdu_op = MDU_MFLO;
        #1;
        check({name, " mflo"}, mdu_rdata, m_lo);
        mdu_op = MDU_NONE;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] eh;
        logic [31:0] el;
        logic        upd;
        mdu_op_e     rop;
        logic [31:0] ra;
        logic [31:0] rb;

        vecs[0] = '{MDU_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b1};
        vecs[1] = '{MDU_MULTU, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE, 1'b1};
        vecs[2] = '{MDU_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1};
        vecs[3] = '{MDU_DIVU,  32'd7,         32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[4] = '{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b1};
        vecs[5] = '{MDU_DIVU,  32'd100,       32'd7,        32'd2,         32'd14,        1'b1};
        vecs[6] = '{MDU_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b1};
        vecs[7] = '{MDU_DIV,   32'd5,         32'd0,        32'd1,         32'hFFFF_FFFD, 1'b0};

        reset       = 1'b1;
        mdu_op      = MDU_NONE;
        rs_val      = 32'd0;
        rt_val      = 32'd0;
        int_exc_req = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        m_hi  = 32'd0;
        m_lo  = 32'd0;
        check("reset busy", 32'(busy), 32'd0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        check("reset start", 32'(start), 32'd0);
        check("reset rdata", mdu_rdata, 32'd0);

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt,
                   vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].upd);
        end

        // mthi / mtlo then read back
        mdu_op = MDU_MTHI;
        rs_val = 32'h1234;
        #1;
        check("mthi start", 32'(start), 32'd0);
        tick();
        m_hi = 32'h1234;
        check("mthi hi", hi, m_hi);
        mdu_op = MDU_MFHI;
        #1;
        check("mfhi rdata", mdu_rdata, 32'h1234);
        mdu_op = MDU_MTLO;
        rs_val = 32'hCAFE_0001;
        tick();
        m_lo = 32'hCAFE_0001;
        mdu_op = MDU_MFLO;
        #1;
        check("mflo rdata", mdu_rdata, m_lo);
        mdu_op = MDU_NONE;
        #1;
        check("none rdata", mdu_rdata, 32'd0);

        // flush coinciding with start, and with mthi
        mdu_op      = MDU_DIV;
        rs_val      = 32'd100;
        rt_val      = 32'd3;
        int_exc_req = 1'b1;
        #1;
        check("exc start", 32'(start), 32'd0);
        tick();
        mdu_op = MDU_MTHI;
        rs_val = 32'hAAAA_AAAA;
        check("exc busy", 32'(busy), 32'd0);
        tick();
        int_exc_req = 1'b0;
        mdu_op      = MDU_NONE;
        tick();
        check("exc busy later", 32'(busy), 32'd0);
        check("exc hi", hi, m_hi);
        check("exc lo", lo, m_lo);

        // flush, mtlo and a second mult arriving mid-RUN must not disturb the op
        mdu_op = MDU_MULT;
        rs_val = 32'h10;
        rt_val = 32'h20;
        tick();
        mdu_op = MDU_NONE;
        tick();
        tick();
        int_exc_req = 1'b1;
        mdu_op      = MDU_MTHI;
        rs_val      = 32'hDEAD_BEEF;
        tick();
        int_exc_req = 1'b0;
        mdu_op      = MDU_MTLO;
        tick();
        check("midrun hi held", hi, m_hi);
        mdu_op = MDU_MULT;
        rs_val = 32'd3;
        rt_val = 32'd3;
        tick();
        mdu_op = MDU_NONE;
        m_hi   = 32'd0;
        m_lo   = 32'h200;
        check("midrun busy", 32'(busy), 32'd0);
        check("midrun hi", hi, m_hi);
        check("midrun lo", lo, m_lo);
        tick();
        check("midrun no relaunch", 32'(busy), 32'd0);

        for (int k = 0; k < 30; k++) begin
            rop = mdu_op_e'($urandom_range(1, 4));
            ra  = $urandom;
            case ($urandom_range(0, 9))
                0:       rb = 32'd0;
                1, 2:    rb = $urandom_range(1, 20);
                3:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            model(rop, ra, rb, eh, el, upd);
            run_op($sformatf("rand%0d", k), rop, ra, rb, eh, el, upd);
        end

        // reset two cycles into a mult aborts it
        mdu_op = MDU_MULT;
        rs_val = 32'd5;
        rt_val = 32'd7;
        tick();
        mdu_op = MDU_NONE;
        tick();
        check("rst busy before", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_hi  = 32'd0;
        m_lo  = 32'd0;
        check("rst busy", 32'(busy), 32'd0);
        check("rst hi", hi, m_hi);
        check("rst lo", lo, m_lo);
        repeat (8) tick();
        check("rst no commit hi", hi, m_hi);
        check("rst no commit lo", lo, m_lo);
        check("rst busy later", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
